// File: rtl/core_pfm_bridge.sv
// Core-side bridge to the prefetch monitor: buffers decode/retire events out and predictions in.
// Optional macro CORE_PFM_DROP_EN: drop decode events on a full FIFO and count them (dec_drop_cnt).

module core_pfm_fifo #(
    parameter int unsigned W         = 8,
    parameter int unsigned DEPTH     = 4,
    parameter bit          KEEP_HEAD = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] head_data,
    output logic         empty,
    output logic         full
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic          do_push, do_pop, keep;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign head_data = mem_q[rd_ptr_q];
    assign do_push   = push && !full && !flush;
    assign do_pop    = pop && !empty;
    // A presented head that was not taken this cycle must survive a flush.
    assign keep      = KEEP_HEAD && !empty && !pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (flush) begin
            if (keep) begin
                wr_ptr_d = rd_ptr_q + 1'b1;
                count_d  = CW'(1);
            end else begin
                wr_ptr_d = rd_ptr_d;
                count_d  = '0;
            end
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

module core_pfm_bridge #(
    parameter int unsigned PC_W       = 64,
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned ID_W       = 8,
    parameter int unsigned DEC_DEPTH  = 4,
    parameter int unsigned RET_DEPTH  = 4,
    parameter int unsigned PRED_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   dec_valid,
    output logic                   dec_retry,
    input  logic [PC_W-1:0]        dec_pc,
    input  logic [ID_W-1:0]        dec_id,
    input  logic                   dec_is_st,
    output logic [PC_W+ID_W:0]     coretopfm_dec,
    output logic                   coretopfm_dec_valid,
    input  logic                   coretopfm_dec_retry,
    input  logic                   ret_valid,
    output logic                   ret_retry,
    input  logic [ID_W-1:0]        ret_id,
    input  logic [ADDR_W-1:0]      ret_addr,
    output logic [ID_W+ADDR_W-1:0] coretopfm_retire,
    output logic                   coretopfm_retire_valid,
    input  logic                   coretopfm_retire_retry,
    input  logic [ID_W+ADDR_W-1:0] pfmtocore_pred,
    input  logic                   pfmtocore_pred_valid,
    output logic                   pfmtocore_pred_retry,
    output logic                   pred_valid,
    input  logic                   pred_retry,
    output logic [ID_W-1:0]        pred_id,
    output logic [ADDR_W-1:0]      pred_addr
`ifdef CORE_PFM_DROP_EN
    ,
    output logic [15:0]            dec_drop_cnt
`endif
);
    localparam int unsigned DEC_W = PC_W + ID_W + 1;
    localparam int unsigned RET_W = ID_W + ADDR_W;

    logic             dec_empty, dec_full, dec_push, dec_pop;
    logic             ret_empty, ret_full, ret_push, ret_pop;
    logic             pred_empty, pred_full, pred_push, pred_pop;
    logic [DEC_W-1:0] dec_head;
    logic [RET_W-1:0] ret_head, pred_head;

`ifdef CORE_PFM_DROP_EN
    logic        dec_drop;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    assign dec_retry    = 1'b0;
    // The FIFO itself refuses the write when full or flushing; those events are the drops.
    assign dec_push     = dec_valid;
    assign dec_drop     = dec_valid && (dec_full || flush);
    assign dec_drop_cnt = drop_cnt_q;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (dec_drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end
`else
    assign dec_retry = dec_full || flush;
    assign dec_push  = dec_valid && !dec_retry;
`endif

    assign ret_retry            = ret_full;
    assign ret_push             = ret_valid && !ret_retry;
    assign pfmtocore_pred_retry = pred_full || flush;
    assign pred_push            = pfmtocore_pred_valid && !pfmtocore_pred_retry;

    assign coretopfm_dec_valid    = !dec_empty;
    assign coretopfm_dec          = dec_head;
    // Retires wait until every earlier decode event has reached the monitor.
    assign coretopfm_retire_valid = !ret_empty && dec_empty;
    assign coretopfm_retire       = ret_head;
    assign pred_valid             = !pred_empty;
    assign pred_id                = pred_head[RET_W-1:ADDR_W];
    assign pred_addr              = pred_head[ADDR_W-1:0];

    assign dec_pop  = coretopfm_dec_valid && !coretopfm_dec_retry;
    assign ret_pop  = coretopfm_retire_valid && !coretopfm_retire_retry;
    assign pred_pop = pred_valid && !pred_retry;

    core_pfm_fifo #(.W(DEC_W), .DEPTH(DEC_DEPTH), .KEEP_HEAD(1'b1)) u_dec_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (dec_push),
        .push_data ({dec_pc, dec_id, dec_is_st}),
        .pop       (dec_pop),
        .flush     (flush),
        .head_data (dec_head),
        .empty     (dec_empty),
        .full      (dec_full)
    );

    core_pfm_fifo #(.W(RET_W), .DEPTH(RET_DEPTH), .KEEP_HEAD(1'b0)) u_ret_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (ret_push),
        .push_data ({ret_id, ret_addr}),
        .pop       (ret_pop),
        .flush     (1'b0),
        .head_data (ret_head),
        .empty     (ret_empty),
        .full      (ret_full)
    );

    core_pfm_fifo #(.W(RET_W), .DEPTH(PRED_DEPTH), .KEEP_HEAD(1'b0)) u_pred_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (pred_push),
        .push_data (pfmtocore_pred),
        .pop       (pred_pop),
        .flush     (flush),
        .head_data (pred_head),
        .empty     (pred_empty),
        .full      (pred_full)
    );
endmodule

// File: tb/tb_core_pfm_bridge.sv
// Scoreboard bench for core_pfm_bridge: stimulus queues expected transfers, a negedge monitor checks them.
module tb_core_pfm_bridge;
    localparam int PC_W   = 64;
    localparam int ADDR_W = 64;
    localparam int ID_W   = 8;
`ifdef CORE_PFM_DROP_EN
    localparam bit DROP_MODE = 1'b1;
`else
    localparam bit DROP_MODE = 1'b0;
`endif

    typedef logic [127:0] val_t;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   flush = 1'b0;
    logic                   dec_valid = 1'b0;
    logic                   dec_retry;
    logic [PC_W-1:0]        dec_pc = '0;
    logic [ID_W-1:0]        dec_id = '0;
    logic                   dec_is_st = 1'b0;
    logic [PC_W+ID_W:0]     coretopfm_dec;
    logic                   coretopfm_dec_valid;
    logic                   coretopfm_dec_retry = 1'b0;
    logic                   ret_valid = 1'b0;
    logic                   ret_retry;
    logic [ID_W-1:0]        ret_id = '0;
    logic [ADDR_W-1:0]      ret_addr = '0;
    logic [ID_W+ADDR_W-1:0] coretopfm_retire;
    logic                   coretopfm_retire_valid;
    logic                   coretopfm_retire_retry = 1'b0;
    logic [ID_W+ADDR_W-1:0] pfmtocore_pred = '0;
    logic                   pfmtocore_pred_valid = 1'b0;
    logic                   pfmtocore_pred_retry;
    logic                   pred_valid;
    logic                   pred_retry = 1'b0;
    logic [ID_W-1:0]        pred_id;
    logic [ADDR_W-1:0]      pred_addr;
`ifdef CORE_PFM_DROP_EN
    logic [15:0]            dec_drop_cnt;
`endif

    core_pfm_bridge #(
        .PC_W(PC_W), .ADDR_W(ADDR_W), .ID_W(ID_W),
        .DEC_DEPTH(4), .RET_DEPTH(4), .PRED_DEPTH(2)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .flush                  (flush),
        .dec_valid              (dec_valid),
        .dec_retry              (dec_retry),
        .dec_pc                 (dec_pc),
        .dec_id                 (dec_id),
        .dec_is_st              (dec_is_st),
        .coretopfm_dec          (coretopfm_dec),
        .coretopfm_dec_valid    (coretopfm_dec_valid),
        .coretopfm_dec_retry    (coretopfm_dec_retry),
        .ret_valid              (ret_valid),
        .ret_retry              (ret_retry),
        .ret_id                 (ret_id),
        .ret_addr               (ret_addr),
        .coretopfm_retire       (coretopfm_retire),
        .coretopfm_retire_valid (coretopfm_retire_valid),
        .coretopfm_retire_retry (coretopfm_retire_retry),
        .pfmtocore_pred         (pfmtocore_pred),
        .pfmtocore_pred_valid   (pfmtocore_pred_valid),
        .pfmtocore_pred_retry   (pfmtocore_pred_retry),
        .pred_valid             (pred_valid),
        .pred_retry             (pred_retry),
        .pred_id                (pred_id),
        .pred_addr              (pred_addr)
`ifdef CORE_PFM_DROP_EN
        ,
        .dec_drop_cnt           (dec_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_drop = 0;
    val_t exp_dec[$];
    val_t exp_ret[$];
    val_t exp_pred[$];

    task automatic check(input string name, input val_t act, input val_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dec_put(input logic [63:0] pc, input logic [7:0] id, input logic st,
                           input logic exp_retry, input logic accept);
        dec_valid = 1'b1;
        dec_pc    = pc;
        dec_id    = id;
        dec_is_st = st;
        #1;
        check("dec_retry", val_t'(dec_retry), val_t'(exp_retry));
        if (accept) exp_dec.push_back(val_t'({pc, id, st}));
        else if (DROP_MODE) exp_drop++;
        step();
        dec_valid = 1'b0;
    endtask

    task automatic ret_put(input logic [7:0] id, input logic [63:0] addr,
                           input logic exp_retry, input logic accept);
        ret_valid = 1'b1;
        ret_id    = id;
        ret_addr  = addr;
        #1;
        check("ret_retry", val_t'(ret_retry), val_t'(exp_retry));
        if (accept) exp_ret.push_back(val_t'({id, addr}));
        step();
        ret_valid = 1'b0;
    endtask

    task automatic pfm_put(input logic [7:0] id, input logic [63:0] addr,
                           input logic exp_retry, input logic accept);
        pfmtocore_pred_valid = 1'b1;
        pfmtocore_pred       = {id, addr};
        #1;
        check("pred_in_retry", val_t'(pfmtocore_pred_retry), val_t'(exp_retry));
        if (accept) exp_pred.push_back(val_t'({id, addr}));
        step();
        pfmtocore_pred_valid = 1'b0;
    endtask

    // Monitor: pops expectations on every completed transfer and checks hold-stability under retry.
    logic prev_dec_hold = 1'b0, prev_ret_hold = 1'b0, prev_pred_hold = 1'b0;
    val_t prev_dec_data, prev_ret_data, prev_pred_data;

    always @(negedge clk) begin
        val_t e;
        if (reset) begin
            prev_dec_hold  = 1'b0;
            prev_ret_hold  = 1'b0;
            prev_pred_hold = 1'b0;
        end else begin
            if (prev_dec_hold) begin
                check("dec_hold_valid", val_t'(coretopfm_dec_valid), val_t'(1));
                check("dec_hold_data", val_t'(coretopfm_dec), prev_dec_data);
            end
            if (prev_ret_hold && coretopfm_retire_valid)
                check("ret_hold_data", val_t'(coretopfm_retire), prev_ret_data);
            if (prev_pred_hold) begin
                check("pred_hold_valid", val_t'(pred_valid), val_t'(1));
                check("pred_hold_data", val_t'({pred_id, pred_addr}), prev_pred_data);
            end
            if (coretopfm_dec_valid && !coretopfm_dec_retry) begin
                if (exp_dec.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL dec_unexpected: got %0h, expected no transfer", coretopfm_dec);
                end else begin
                    e = exp_dec.pop_front();
                    check("dec_payload", val_t'(coretopfm_dec), e);
                end
            end
            if (coretopfm_retire_valid && !coretopfm_retire_retry) begin
                if (exp_ret.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL ret_unexpected: got %0h, expected no transfer", coretopfm_retire);
                end else begin
                    e = exp_ret.pop_front();
                    check("ret_payload", val_t'(coretopfm_retire), e);
                end
            end
            if (pred_valid && !pred_retry) begin
                if (exp_pred.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL pred_unexpected: got %0h, expected no transfer", {pred_id, pred_addr});
                end else begin
                    e = exp_pred.pop_front();
                    check("pred_payload", val_t'({pred_id, pred_addr}), e);
                end
            end
            prev_dec_hold  = coretopfm_dec_valid && coretopfm_dec_retry;
            prev_dec_data  = val_t'(coretopfm_dec);
            prev_ret_hold  = coretopfm_retire_valid && coretopfm_retire_retry;
            prev_ret_data  = val_t'(coretopfm_retire);
            prev_pred_hold = pred_valid && pred_retry && !flush;
            prev_pred_data = val_t'({pred_id, pred_addr});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_dec_valid", val_t'(coretopfm_dec_valid), 0);
        check("rst_ret_valid", val_t'(coretopfm_retire_valid), 0);
        check("rst_pred_valid", val_t'(pred_valid), 0);
        check("rst_dec_retry", val_t'(dec_retry), 0);
        check("rst_ret_retry", val_t'(ret_retry), 0);
        check("rst_pred_in_retry", val_t'(pfmtocore_pred_retry), 0);
        check("rst_dec_data", val_t'(coretopfm_dec), 0);
        check("rst_ret_data", val_t'(coretopfm_retire), 0);
        check("rst_pred_data", val_t'({pred_id, pred_addr}), 0);
        reset = 1'b0;
        step();

        // Single decode, monitor ready: visible one cycle later, taken immediately
        dec_put(64'h1000, 8'd3, 1'b0, 1'b0, 1'b1);
        check("t1_dec_valid", val_t'(coretopfm_dec_valid), 1);
        check("t1_dec_data", val_t'(coretopfm_dec), val_t'({64'h1000, 8'd3, 1'b0}));
        step();
        check("t1_dec_popped", val_t'(coretopfm_dec_valid), 0);

        // Fill decode FIFO under back-pressure, then overflow
        coretopfm_dec_retry = 1'b1;
        for (int i = 0; i < 4; i++)
            dec_put(64'h1100 + 64'(i * 4), 8'(16 + i), 1'(i), 1'b0, 1'b1);
        repeat (DROP_MODE ? 3 : 1) dec_put(64'hdead, 8'hee, 1'b1, !DROP_MODE, 1'b0);
`ifdef CORE_PFM_DROP_EN
        check("drop_cnt_3", val_t'(dec_drop_cnt), 3);
`endif
        check("t2_head", val_t'(coretopfm_dec), val_t'({64'h1100, 8'd16, 1'b0}));
        coretopfm_dec_retry = 1'b0;
        repeat (4) step();
        check("t2_drained", val_t'(coretopfm_dec_valid), 0);
        check("t2_exp_left", val_t'(exp_dec.size()), 0);

        // Retire must wait for pending decode
        coretopfm_dec_retry = 1'b1;
        dec_put(64'h3000, 8'd3, 1'b1, 1'b0, 1'b1);
        ret_put(8'd3, 64'habc0, 1'b0, 1'b1);
        check("t3_ret_blocked0", val_t'(coretopfm_retire_valid), 0);
        step();
        check("t3_ret_blocked1", val_t'(coretopfm_retire_valid), 0);
        coretopfm_dec_retry = 1'b0;
        #1;
        check("t3_ret_blocked2", val_t'(coretopfm_retire_valid), 0);
        step();
        check("t3_ret_released", val_t'(coretopfm_retire_valid), 1);
        step();
        check("t3_ret_done", val_t'(coretopfm_retire_valid), 0);

        // Prediction FIFO full, full-with-pop keeps retry, then drain in order
        pred_retry = 1'b1;
        pfm_put(8'd7, 64'h2040, 1'b0, 1'b1);
        pfm_put(8'd8, 64'h2080, 1'b0, 1'b1);
        check("t4_pred_head", val_t'({pred_id, pred_addr}), val_t'({8'd7, 64'h2040}));
        pred_retry = 1'b0;
        pfm_put(8'd9, 64'h20c0, 1'b1, 1'b0);
        pfm_put(8'd9, 64'h20c0, 1'b0, 1'b1);
        repeat (2) step();
        check("t4_pred_drained", val_t'(pred_valid), 0);

        // Retire FIFO full under back-pressure
        coretopfm_retire_retry = 1'b1;
        for (int i = 0; i < 4; i++)
            ret_put(8'(8'h40 + i), 64'h8000 + 64'(i * 64), 1'b0, 1'b1);
        ret_put(8'h50, 64'h9000, 1'b1, 1'b0);

        // Flush: dec keeps retried head, pred emptied, ret untouched
        coretopfm_dec_retry = 1'b1;
        dec_put(64'h5000, 8'h21, 1'b0, 1'b0, 1'b1);
        dec_put(64'h5004, 8'h22, 1'b1, 1'b0, 1'b1);
        dec_put(64'h5008, 8'h23, 1'b0, 1'b0, 1'b1);
        pred_retry = 1'b1;
        pfm_put(8'h31, 64'h6000, 1'b0, 1'b1);
        pfm_put(8'h32, 64'h6040, 1'b0, 1'b1);
        flush = 1'b1;
        #1;
        check("t5_pred_in_retry", val_t'(pfmtocore_pred_retry), 1);
        dec_put(64'h500c, 8'h24, 1'b0, !DROP_MODE, 1'b0);
        flush = 1'b0;
        while (exp_dec.size() > 1) void'(exp_dec.pop_back());
        exp_pred.delete();
        check("t5_pred_valid", val_t'(pred_valid), 0);
        check("t5_dec_valid", val_t'(coretopfm_dec_valid), 1);
        check("t5_dec_head", val_t'(coretopfm_dec), val_t'({64'h5000, 8'h21, 1'b0}));
        check("t5_ret_full", val_t'(ret_retry), 1);
        check("t5_ret_blocked", val_t'(coretopfm_retire_valid), 0);
        for (int i = 0; i < 3; i++)
            dec_put(64'h5100 + 64'(i * 4), 8'(8'h60 + i), 1'b0, 1'b0, 1'b1);
        dec_put(64'h5200, 8'h6f, 1'b1, !DROP_MODE, 1'b0);
        coretopfm_dec_retry = 1'b0;
        repeat (5) step();
        check("t5_dec_drained", val_t'(coretopfm_dec_valid), 0);
        check("t5_ret_valid", val_t'(coretopfm_retire_valid), 1);
        coretopfm_retire_retry = 1'b0;
        pred_retry = 1'b0;
        repeat (5) step();
        check("t5_ret_drained", val_t'(coretopfm_retire_valid), 0);
        check("dec_exp_left", val_t'(exp_dec.size()), 0);
        check("ret_exp_left", val_t'(exp_ret.size()), 0);
        check("pred_exp_left", val_t'(exp_pred.size()), 0);
`ifdef CORE_PFM_DROP_EN
        check("drop_cnt_final", val_t'(dec_drop_cnt), val_t'(exp_drop));
`endif

        // Asynchronous reset while a decode transfer is pending
        coretopfm_dec_retry = 1'b1;
        dec_put(64'h7000, 8'h70, 1'b0, 1'b0, 1'b1);
        coretopfm_dec_retry = 1'b0;
        #2;
        reset = 1'b1;
        exp_dec.delete();
        #1;
        check("rst_async_valid", val_t'(coretopfm_dec_valid), 0);
        check("rst_async_data", val_t'(coretopfm_dec), 0);
        step();
        reset = 1'b0;
        step();
        check("rst_no_transfer", val_t'(coretopfm_dec_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/core_pfm_bridge.md
Name: core_pfm_bridge

Overview:
- Core-side endpoint of the prefetch-monitor protocol, facing the pfmonitor block from the core.
- Collects decode events and retire events from the core pipeline, buffers them, and drives them to the monitor with valid/retry handshakes.
- Accepts prefetch predictions from the monitor and buffers them for the core fetch/LSU.
- Sits between the core pipeline and the monitor; it is the counterpart of the monitor's dec/retire inputs and pred output.

Parameters:
PC_W, 64, decode PC width
ADDR_W, 64, retire/prediction data-address width
ID_W, 8, instruction tag width
DEC_DEPTH, 4, decode FIFO entries (power of 2, >=2)
RET_DEPTH, 4, retire FIFO entries (power of 2, >=2)
PRED_DEPTH, 2, prediction FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
flush  in  1  pipeline flush pulse
dec_valid  in  1  core decode event valid
dec_retry  out  1  decode event not accepted this cycle
dec_pc  in  PC_W  PC of decoded memory op
dec_id  in  ID_W  instruction tag
dec_is_st  in  1  1=store, 0=load
coretopfm_dec  out  PC_W+ID_W+1  {pc,id,is_st} to monitor
coretopfm_dec_valid  out  1  decode event valid to monitor
coretopfm_dec_retry  in  1  monitor back-pressure
ret_valid  in  1  core retire event valid
ret_retry  out  1  retire event not accepted
ret_id  in  ID_W  retired tag
ret_addr  in  ADDR_W  resolved data address
coretopfm_retire  out  ID_W+ADDR_W  {id,addr} to monitor
coretopfm_retire_valid  out  1  retire event valid to monitor
coretopfm_retire_retry  in  1  monitor back-pressure
pfmtocore_pred  in  ID_W+ADDR_W  {id,addr} prediction from monitor
pfmtocore_pred_valid  in  1  prediction valid
pfmtocore_pred_retry  out  1  prediction not accepted
pred_valid  out  1  prediction to core
pred_retry  in  1  core back-pressure
pred_id  out  ID_W  predicted tag
pred_addr  out  ADDR_W  predicted prefetch address

Behaviour:
- Handshake on every channel: transfer iff valid && !retry in the same cycle. The sender holds valid and data stable while retry=1.
- Reset: all FIFOs empty. coretopfm_dec_valid=0, coretopfm_retire_valid=0, pred_valid=0, dec_retry=0, ret_retry=0, pfmtocore_pred_retry=0. All data outputs are 0.
- Each FIFO is circular with wrap-around pointers and a count register. All outputs are driven from FIFO storage and head-valid flags; no input-to-output combinational path on data.
- Latency: an entry pushed at edge N is presentable at cycle N+1.
- Retry outputs:
  - dec_retry = dec FIFO full || flush.
  - ret_retry = ret FIFO full.
  - pfmtocore_pred_retry = pred FIFO full || flush.
  - Retry is computed from registered count and does not look at the same-cycle pop.
- Full FIFO with simultaneous pop: retry stays 1 that cycle. The count decrements and retry drops the next cycle.
- Empty FIFO with simultaneous push: valid rises next cycle; no bypass.
- Ordering rule: coretopfm_retire_valid = ret FIFO non-empty && dec FIFO empty. A retire is never sent while any decode event is still pending. Decode has no dependency on retire.
- flush (one cycle):
  - Pred FIFO is cleared at the edge, including its head. pred_valid is 0 the next cycle. The core channel permits withdrawal on flush.
  - Dec FIFO keeps only its head entry if coretopfm_dec_valid=1 and that entry was not accepted this cycle, because the monitor protocol forbids withdrawal. All other dec entries are dropped. A head accepted this cycle is popped normally.
  - Ret FIFO is unaffected.
- reset asserted mid-transfer: all state clears immediately (asynchronous). No handshake completes in that cycle.
- Pointer/count widths: log2(DEPTH) pointers; count is log2(DEPTH)+1 bits.

Optional Feature:
- Macro CORE_PFM_DROP_EN.
- Defined:
  - Decode events arriving when the dec FIFO is full are silently dropped; dec_retry is forced to 0, including during flush, where the event is also dropped.
  - Adds output dec_drop_cnt (16 bits): reset 0, increments by 1 per dropped event, saturates at 16'hFFFF.
- Not defined: blocking behaviour as above, and the port is absent.

Test Plan:
- Single decode {pc=0x1000,id=3,st=0} with monitor ready -> coretopfm_dec_valid=1 exactly one cycle later with payload {0x1000,3,0}; popped the same cycle.
- Hold coretopfm_dec_retry=1 and push 5 decodes (DEC_DEPTH=4) -> dec_retry=1 on the 5th. Release retry -> 4 events delivered in push order; payload stays stable throughout the retry.
- Retire id=3 pushed while the dec FIFO holds id=3 with monitor retrying -> coretopfm_retire_valid stays 0 until dec id=3 is accepted, then asserts the following cycle.
- Two predictions {id=7,addr=0x2040}, {id=8,addr=0x2080} with pred_retry=1 -> 3rd prediction sees pfmtocore_pred_retry=1. Release -> delivered in order.
- flush while dec FIFO holds 3 entries with head presented and retried, and pred FIFO holds 2 -> next cycle dec count=1 (same head payload), pred_valid=0, ret FIFO count unchanged.
- CORE_PFM_DROP_EN: fill dec FIFO, push 3 more -> dec_retry=0, dec_drop_cnt=3, FIFO contents unchanged.
